// File: rtl/random_multi_gen.sv
// Multi-channel random value source: per-channel rising-edge requests served from a
// free-running wrap counter (MODE=0) or a shared 16-bit LFSR with rejection sampling (MODE=1).
`timescale 1ns/1ps
module random_multi_gen #(
  parameter int          NUM_CH    = 4,
  parameter int          WIDTH     = 6,
  parameter int          MIN_VAL   = 0,
  parameter int          MAX_VAL   = 63,
  parameter int          MODE      = 1,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          MAX_TRIES = 4
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    enable,
  input  logic                    seed_load,
  input  logic [15:0]             seed_in,
  input  logic [NUM_CH-1:0]       rise,
  output logic [NUM_CH*WIDTH-1:0] dout,
  output logic [NUM_CH-1:0]       valid,
  output logic [NUM_CH-1:0]       busy
);

  localparam logic [WIDTH-1:0] MIN_W     = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MID_W     = WIDTH'((MIN_VAL + MAX_VAL) / 2);
  localparam logic [3:0]       TRIES_MAX = 4'(MAX_TRIES);

  typedef enum logic {IDLE, RETRY} state_e;

  logic [WIDTH-1:0]        cnt_q, cnt_d;
  logic [15:0]             lfsr_q, lfsr_d;
  logic                    fb;
  logic [NUM_CH-1:0]       rise_q;
  logic                    armed_q;
  logic [NUM_CH-1:0]       edge_w;
  logic [NUM_CH*WIDTH-1:0] dout_q, dout_d;
  logic [NUM_CH-1:0]       valid_q, valid_d;
  state_e                  state_q [NUM_CH];
  state_e                  state_d [NUM_CH];
  logic [3:0]              tries_q [NUM_CH];
  logic [3:0]              tries_d [NUM_CH];
  logic [WIDTH-1:0]        cand    [NUM_CH];

  function automatic logic in_range(input logic [WIDTH-1:0] v);
    return (int'(v) >= MIN_VAL) && (int'(v) <= MAX_VAL);
  endfunction

  assign fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  // armed_q masks the first cycle after reset so a line held high through reset is not an edge
  assign edge_w = rise & ~rise_q & {NUM_CH{armed_q}};

  always_comb begin
    cnt_d = (int'(cnt_q) >= MAX_VAL) ? MIN_W : cnt_q + 1'b1;
    if (!enable) cnt_d = cnt_q;
    if (seed_load)   lfsr_d = (seed_in == 16'd0) ? SEED : seed_in;
    else if (enable) lfsr_d = {lfsr_q[14:0], fb};
    else             lfsr_d = lfsr_q;
  end

  always_comb begin : cand_gen
    logic [31:0] dbl;
    dbl = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      dbl     = {lfsr_q, lfsr_q} << ((3 * i) % 16);
      cand[i] = dbl[16 +: WIDTH];
    end
  end

  always_comb begin
    dout_d  = dout_q;
    valid_d = '0;
    state_d = state_q;
    tries_d = tries_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (MODE == 0) begin
        if (edge_w[i]) begin
          dout_d[i*WIDTH +: WIDTH] = cnt_q;
          valid_d[i]               = 1'b1;
        end
      end else begin
        case (state_q[i])
          IDLE: begin
            if (edge_w[i]) begin
              if (in_range(cand[i])) begin
                dout_d[i*WIDTH +: WIDTH] = cand[i];
                valid_d[i]               = 1'b1;
              end else begin
                state_d[i] = RETRY;
                tries_d[i] = 4'd1;
              end
            end
          end
          RETRY: begin
            if (in_range(cand[i])) begin
              dout_d[i*WIDTH +: WIDTH] = cand[i];
              valid_d[i]               = 1'b1;
              state_d[i]               = IDLE;
              tries_d[i]               = 4'd0;
            end else if (tries_q[i] == TRIES_MAX) begin
              // out of retries: the counter value is always in range
              dout_d[i*WIDTH +: WIDTH] = cnt_q;
              valid_d[i]               = 1'b1;
              state_d[i]               = IDLE;
              tries_d[i]               = 4'd0;
            end else begin
              tries_d[i] = tries_q[i] + 4'd1;
            end
          end
          default: state_d[i] = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      cnt_q   <= MIN_W;
      lfsr_q  <= SEED;
      rise_q  <= '0;
      armed_q <= 1'b0;
      dout_q  <= {NUM_CH{MID_W}};
      valid_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= IDLE;
        tries_q[i] <= 4'd0;
      end
    end else begin
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      rise_q  <= rise;
      armed_q <= 1'b1;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      state_q <= state_d;
      tries_q <= tries_d;
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < NUM_CH; i++) busy[i] = (state_q[i] == RETRY);
  end

  assign dout  = dout_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_random_multi_gen.sv
// Bench for random_multi_gen: four configurations share one stimulus stream and are
// checked every cycle against an integer-level reference model, plus directed literal cases.
`timescale 1ns/1ps
module tb_random_multi_gen;

  localparam int NI = 4;
  localparam int NC = 4;
  localparam int W  = 6;
  localparam int SEEDV = 'hACE1;
  localparam int P_MODE [NI] = '{0, 0, 1, 1};
  localparam int P_MIN  [NI] = '{0, 5, 0, 60};
  localparam int P_MAX  [NI] = '{63, 9, 63, 62};
  localparam int P_TRY  [NI] = '{4, 4, 4, 2};

  logic          clk = 1'b0;
  logic          resetN;
  logic          enable;
  logic          seed_load;
  logic [15:0]   seed_in;
  logic [NC-1:0] rise;
  logic [NC*W-1:0] dout_w  [NI];
  logic [NC-1:0]   valid_w [NI];
  logic [NC-1:0]   busy_w  [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    random_multi_gen #(
      .NUM_CH(NC), .WIDTH(W), .MIN_VAL(P_MIN[g]), .MAX_VAL(P_MAX[g]),
      .MODE(P_MODE[g]), .SEED(16'hACE1), .MAX_TRIES(P_TRY[g])
    ) u_dut (
      .clk(clk), .resetN(resetN), .enable(enable), .seed_load(seed_load),
      .seed_in(seed_in), .rise(rise), .dout(dout_w[g]), .valid(valid_w[g]), .busy(busy_w[g])
    );
  end

  int total = 0;
  int bad   = 0;
  int nprint = 0;

  // reference model state: what the outputs must be after the next clock edge
  bit          m_ok = 1'b0;
  int          m_cnt  [NI];
  int          m_lfsr;
  int          m_dout [NI][NC];
  int          m_pend [NI][NC];
  bit [NC-1:0] m_valid [NI];
  bit [NC-1:0] m_prev;
  bit          m_armed;

  function automatic int lfsr_next(input int l);
    int fb;
    fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
    return ((l << 1) & 'hFFFF) | fb;
  endfunction

  function automatic int rotl16(input int l, input int s);
    int sh;
    sh = s % 16;
    return ((l << sh) | (l >> (16 - sh))) & 'hFFFF;
  endfunction

  task automatic chk(input string name, input int k, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      if (nprint < 40) begin
        nprint++;
        $display("FAIL %s inst%0d t=%0t got=%0d want=%0d", name, k, $time, got, want);
      end
    end
  endtask

  task automatic model_step();
    bit [NC-1:0] edges;
    int cand;
    bit inr;
    if (!resetN) begin
      for (int k = 0; k < NI; k++) begin
        m_cnt[k]   = P_MIN[k];
        m_valid[k] = '0;
        for (int c = 0; c < NC; c++) begin
          m_dout[k][c] = (P_MIN[k] + P_MAX[k]) / 2;
          m_pend[k][c] = 0;
        end
      end
      m_lfsr  = SEEDV;
      m_prev  = '0;
      m_armed = 1'b0;
    end else begin
      edges = m_armed ? (rise & ~m_prev) : '0;
      for (int k = 0; k < NI; k++) begin
        m_valid[k] = '0;
        for (int c = 0; c < NC; c++) begin
          cand = rotl16(m_lfsr, 3 * c) % (1 << W);
          inr  = (cand >= P_MIN[k]) && (cand <= P_MAX[k]);
          if (P_MODE[k] == 0) begin
            if (edges[c]) begin m_dout[k][c] = m_cnt[k]; m_valid[k][c] = 1'b1; end
          end else if (m_pend[k][c] == 0) begin
            if (edges[c] && inr) begin m_dout[k][c] = cand; m_valid[k][c] = 1'b1; end
            else if (edges[c]) m_pend[k][c] = 1;
          end else if (inr) begin
            m_dout[k][c] = cand; m_valid[k][c] = 1'b1; m_pend[k][c] = 0;
          end else if (m_pend[k][c] == P_TRY[k]) begin
            m_dout[k][c] = m_cnt[k]; m_valid[k][c] = 1'b1; m_pend[k][c] = 0;
          end else begin
            m_pend[k][c]++;
          end
        end
        if (enable) m_cnt[k] = P_MIN[k] + (m_cnt[k] - P_MIN[k] + 1) % (P_MAX[k] - P_MIN[k] + 1);
      end
      if (seed_load)   m_lfsr = (seed_in == 16'd0) ? SEEDV : int'(seed_in);
      else if (enable) m_lfsr = lfsr_next(m_lfsr);
      m_prev  = rise;
      m_armed = 1'b1;
    end
    m_ok = 1'b1;
  endtask

  task automatic compare_all();
    bit [NC-1:0] eb;
    for (int k = 0; k < NI; k++) begin
      for (int c = 0; c < NC; c++)
        chk($sformatf("dout%0d", c), k, int'(dout_w[k][c*W +: W]), m_dout[k][c]);
      for (int c = 0; c < NC; c++) eb[c] = (m_pend[k][c] != 0);
      chk("valid", k, int'(valid_w[k]), int'(m_valid[k]));
      chk("busy",  k, int'(busy_w[k]),  int'(eb));
    end
  endtask

  // one clock: check at the falling edge, advance the model, then return 1ns after the rising edge
  task automatic cyc();
    @(negedge clk);
    if (m_ok) compare_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetN = 1'b0; enable = 1'b1; seed_load = 1'b0; seed_in = '0; rise = '0;

    chk("pin_lfsr", -1, lfsr_next('hACE1), 'h59C3);
    chk("pin_rot",  -1, rotl16('hACE1, 3), 'h670D);

    repeat (3) cyc();
    chk("rst_dout3", 3, int'(dout_w[3][0 +: W]), 61);
    chk("rst_valid", 2, int'(valid_w[2]), 0);
    chk("rst_busy",  3, int'(busy_w[3]), 0);

    // counter latch: edge sampled while cnt is 10 (wrap range 5..9 yields 5)
    resetN = 1'b1;
    repeat (10) cyc();
    rise[0] = 1'b1;
    cyc();
    chk("t1_dout", 0, int'(dout_w[0][0 +: W]), 10);
    chk("t1_valid", 0, int'(valid_w[0][0]), 1);
    chk("t1_wrap", 1, int'(dout_w[1][0 +: W]), 5);
    cyc();
    chk("t1_pulse", 0, int'(valid_w[0][0]), 0);
    chk("t1_hold", 0, int'(dout_w[0][0 +: W]), 10);

    // all channels together from the seed value
    rise = '0;
    repeat (6) cyc();
    seed_load = 1'b1; seed_in = 16'd0;
    cyc();
    seed_load = 1'b0; rise = '1;
    cyc();
    chk("t3_valid", 2, int'(valid_w[2]), 'hF);
    chk("t3_ch0", 2, int'(dout_w[2][0*W +: W]), 33);
    chk("t3_ch1", 2, int'(dout_w[2][1*W +: W]), 13);
    chk("t3_ch2", 2, int'(dout_w[2][2*W +: W]), 43);
    chk("t3_ch3", 2, int'(dout_w[2][3*W +: W]), 25);

    // forced rejection: seed 1 gives candidates 1,2,4 for channel 0
    rise = '0;
    repeat (6) cyc();
    seed_load = 1'b1; seed_in = 16'd1;
    cyc();
    seed_load = 1'b0; rise = 4'b0001;
    cyc();
    chk("t4_busy1", 3, int'(busy_w[3][0]), 1);
    chk("t4_nov1",  3, int'(valid_w[3][0]), 0);
    cyc();
    chk("t4_busy2", 3, int'(busy_w[3][0]), 1);
    chk("t4_nov2",  3, int'(valid_w[3][0]), 0);
    cyc();
    chk("t4_busy0", 3, int'(busy_w[3][0]), 0);
    chk("t4_valid", 3, int'(valid_w[3][0]), 1);
    chk("t4_range", 3, int'(dout_w[3][0 +: W] >= 6'd60 && dout_w[3][0 +: W] <= 6'd62), 1);

    // reset in the middle of a retry, request line held high throughout
    rise = '0;
    repeat (6) cyc();
    seed_load = 1'b1; seed_in = 16'd1;
    cyc();
    seed_load = 1'b0; rise = 4'b0001;
    cyc();
    chk("t6_busy", 3, int'(busy_w[3][0]), 1);
    resetN = 1'b0;
    cyc();
    chk("t6_dout",  3, int'(dout_w[3][0 +: W]), 61);
    chk("t6_busy0", 3, int'(busy_w[3]), 0);
    chk("t6_valid", 3, int'(valid_w[3]), 0);
    resetN = 1'b1;
    for (int n = 0; n < 3; n++) begin
      cyc();
      for (int k = 0; k < NI; k++) chk("t6_noserve", k, int'(valid_w[k]), 0);
    end

    // randomized run
    for (int n = 0; n < 3000; n++) begin
      resetN    = ($urandom_range(0, 299) != 0);
      enable    = ($urandom_range(0, 7) != 0);
      seed_load = ($urandom_range(0, 39) == 0);
      seed_in   = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(0, 65535));
      rise      = rise ^ 4'($urandom & $urandom);
      cyc();
    end
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
